// File: rtl/tile_sequencer_pkg.sv
// rtl/tile_sequencer_pkg.sv - shared types, defaults and helpers for the tile sequencer
package tile_sequencer_pkg;

    localparam int SYS_ROWS       = 4;
    localparam int SYS_COLS       = 4;
    localparam int DEF_MAX_A_ROWS = 256;
    localparam int DEF_MAX_TILES  = 16;

    function automatic int max_i(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int DEF_A_W  = $clog2(DEF_MAX_A_ROWS + 1);
    localparam int DEF_T_W  = $clog2(DEF_MAX_TILES + 1);
    localparam int DEF_PH_W = $clog2(max_i(DEF_MAX_A_ROWS, SYS_ROWS + SYS_COLS) + 1);

    typedef enum logic [2:0] {
        TS_IDLE   = 3'd0,
        TS_CLR    = 3'd1,
        TS_WLOAD  = 3'd2,
        TS_STREAM = 3'd3,
        TS_DRAIN  = 3'd4,
        TS_HOLD   = 3'd5,
        TS_DONE   = 3'd6
    } tseq_state_e;

endpackage

// File: rtl/tile_sequencer_valid_skew.sv
// rtl/tile_sequencer_valid_skew.sv - skewed per-column output-valid strobes from input reads
module tile_sequencer_valid_skew #(
    parameter int ROWS = 4,
    parameter int COLS = 4
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_in,
    output logic [COLS-1:0] o_of_valid,
    output logic            o_of_last
);

    localparam int N = ROWS + COLS - 1;

    logic [N-1:0] r_sr;

    // Delay line: tap k carries the input-buffer read strobe delayed by k+1 cycles
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sr <= '0;
        end else begin
            r_sr <= (r_sr << 1) | N'(i_in);
        end
    end

    // Column c sees its partial sum ROWS+c cycles after the activation row entered
    genvar c;
    generate
        for (c = 0; c < COLS; c++) begin : g_col
            assign o_of_valid[c] = r_sr[ROWS+c-1];
        end
        // Final strobe of the last column is the falling edge of that column's window
        if (N > 1) begin : g_last_deep
            assign o_of_last = r_sr[N-1] & ~r_sr[N-2];
        end else begin : g_last_flat
            assign o_of_last = r_sr[0] & ~i_in;
        end
    endgenerate

endmodule

// File: rtl/tile_sequencer.sv
// rtl/tile_sequencer.sv - multi-tile clear/weight-load/stream/drain sequencer for the systolic array
module tile_sequencer
    import tile_sequencer_pkg::*;
#(
    parameter int ROWS       = SYS_ROWS,
    parameter int COLS       = SYS_COLS,
    parameter int MAX_A_ROWS = DEF_MAX_A_ROWS,
    parameter int MAX_TILES  = DEF_MAX_TILES
) (
    input  logic                             i_clk,
    input  logic                             i_rst_n,
    input  logic                             i_start,
    input  logic [$clog2(MAX_A_ROWS+1)-1:0]  i_cfg_a_rows,
    input  logic [$clog2(MAX_TILES+1)-1:0]   i_cfg_tiles,
    input  logic                             i_cfg_accum,
    input  logic                             i_tile_hold,
    output logic                             o_ready,
    output logic                             o_busy,
    output logic                             o_sys_clr,
    output logic                             o_w_buffer_read,
    output logic                             o_if_buffer_read,
    output logic [COLS-1:0]                  o_of_valid,
    output logic                             o_of_last,
    output logic [$clog2(MAX_TILES+1)-1:0]   o_tile_idx,
    output logic                             o_done
);

    localparam int A_W  = $clog2(MAX_A_ROWS + 1);
    localparam int T_W  = $clog2(MAX_TILES + 1);
    localparam int PH_W = $clog2(max_i(MAX_A_ROWS, ROWS + COLS) + 1);

    tseq_state_e     r_state;
    tseq_state_e     w_next;
    tseq_state_e     w_after_tile;
    logic [PH_W-1:0] r_cnt;
    logic [A_W-1:0]  r_a_last;
    logic [T_W-1:0]  r_tiles_last;
    logic [T_W-1:0]  r_tile_idx;
    logic            r_accum;
    logic            w_tile_inc;
    logic            w_wload_end;
    logic            w_stream_end;
    logic            w_drain_end;
    logic            w_last_tile;
    logic            w_if_read;

    assign w_wload_end  = (r_cnt == PH_W'(ROWS - 1));
    assign w_stream_end = (r_cnt == PH_W'(r_a_last));
    assign w_drain_end  = (r_cnt == PH_W'(ROWS + COLS - 2));
    assign w_last_tile  = (r_tile_idx == r_tiles_last);
    // Accumulating runs keep partial sums, so later tiles skip the clear
    assign w_after_tile = r_accum ? TS_WLOAD : TS_CLR;

    // Next-state selection and tile advance decision
    always_comb begin
        w_next     = r_state;
        w_tile_inc = 1'b0;
        case (r_state)
            TS_IDLE: begin
                if (i_start) begin
                    w_next = (i_cfg_tiles == '0) ? TS_DONE : TS_CLR;
                end
            end
            TS_CLR:    w_next = TS_WLOAD;
            TS_WLOAD:  if (w_wload_end)  w_next = TS_STREAM;
            TS_STREAM: if (w_stream_end) w_next = TS_DRAIN;
            TS_DRAIN: begin
                if (w_drain_end) begin
                    if (w_last_tile) begin
                        w_next = TS_DONE;
                    end else if (i_tile_hold) begin
                        w_next = TS_HOLD;
                    end else begin
                        w_next     = w_after_tile;
                        w_tile_inc = 1'b1;
                    end
                end
            end
            TS_HOLD: begin
                if (!i_tile_hold) begin
                    w_next     = w_after_tile;
                    w_tile_inc = 1'b1;
                end
            end
            TS_DONE:   w_next = TS_IDLE;
            default:   w_next = TS_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= TS_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Phase counter restarts on every state change and only runs in timed phases
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (w_next != r_state) begin
            r_cnt <= '0;
        end else if (r_state == TS_WLOAD || r_state == TS_STREAM || r_state == TS_DRAIN) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Configuration is captured once at start; zero activation rows clamp to one
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_a_last     <= '0;
            r_tiles_last <= '0;
            r_accum      <= 1'b0;
            r_tile_idx   <= '0;
        end else if (r_state == TS_IDLE && i_start) begin
            r_a_last     <= (i_cfg_a_rows == '0) ? '0 : i_cfg_a_rows - 1'b1;
            r_tiles_last <= i_cfg_tiles - 1'b1;
            r_accum      <= i_cfg_accum;
            r_tile_idx   <= '0;
        end else if (w_tile_inc) begin
            r_tile_idx <= r_tile_idx + 1'b1;
        end
    end

    assign w_if_read        = (r_state == TS_STREAM);
    assign o_ready          = (r_state == TS_IDLE);
    assign o_busy           = (r_state != TS_IDLE);
    assign o_sys_clr        = (r_state == TS_CLR);
    assign o_w_buffer_read  = (r_state == TS_WLOAD);
    assign o_if_buffer_read = w_if_read;
    assign o_done           = (r_state == TS_DONE);
    assign o_tile_idx       = r_tile_idx;

    tile_sequencer_valid_skew #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) u_valid_skew (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_in       (w_if_read),
        .o_of_valid (o_of_valid),
        .o_of_last  (o_of_last)
    );

endmodule

// File: tb/tb_tile_sequencer.sv
// tb/tb_tile_sequencer.sv - scoreboard bench for tile_sequencer strobe timing
module tb_tile_sequencer;

    localparam int ROWS       = 4;
    localparam int COLS       = 4;
    localparam int MAX_A_ROWS = 256;
    localparam int MAX_TILES  = 16;
    localparam int AW         = $clog2(MAX_A_ROWS + 1);
    localparam int TW         = $clog2(MAX_TILES + 1);

    localparam int B_CLR  = 0;
    localparam int B_W    = 1;
    localparam int B_IF   = 2;
    localparam int B_OV   = 3;
    localparam int B_LAST = 7;
    localparam int B_DONE = 8;

    logic            clk   = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            accum = 1'b0;
    logic            hold  = 1'b0;
    logic [AW-1:0]   a_rows = '0;
    logic [TW-1:0]   tiles  = '0;
    logic            ready, busy, sys_clr, w_read, if_read, of_last, done;
    logic [COLS-1:0] of_valid;
    logic [TW-1:0]   tile_idx;

    tile_sequencer #(
        .ROWS       (ROWS),
        .COLS       (COLS),
        .MAX_A_ROWS (MAX_A_ROWS),
        .MAX_TILES  (MAX_TILES)
    ) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_start          (start),
        .i_cfg_a_rows     (a_rows),
        .i_cfg_tiles      (tiles),
        .i_cfg_accum      (accum),
        .i_tile_hold      (hold),
        .o_ready          (ready),
        .o_busy           (busy),
        .o_sys_clr        (sys_clr),
        .o_w_buffer_read  (w_read),
        .o_if_buffer_read (if_read),
        .o_of_valid       (of_valid),
        .o_of_last        (of_last),
        .o_tile_idx       (tile_idx),
        .o_done           (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            cyc;
        logic [8:0]    vec;
        logic [TW-1:0] tidx;
    } exp_t;

    exp_t          q[$];
    logic [8:0]    sv[0:63];
    logic [TW-1:0] st[0:63];
    int            n_checks = 0;
    int            n_pass   = 0;
    int            base     = 0;
    logic [8:0]    act_vec;

    assign act_vec = {done, of_last, of_valid, if_read, w_read, sys_clr};

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc - base);
    endtask

    // Monitor: every cycle with any strobe high consumes one expected entry
    always @(negedge clk) begin
        if (act_vec != '0) begin
            if (q.size() == 0) begin
                check("unexpected_strobe", int'(act_vec), 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("strobe_cycle", cyc - base, e.cyc - base);
                check("strobe_vector", int'(act_vec), int'(e.vec));
                check("tile_idx", int'(tile_idx), int'(e.tidx));
            end
        end
    end

    task automatic sched_clear();
        for (int i = 0; i < 64; i++) begin
            sv[i] = '0;
            st[i] = '0;
        end
    endtask

    task automatic rng(input int lo, input int hi, input int b);
        for (int i = lo; i <= hi; i++) sv[i][b] = 1'b1;
    endtask

    task automatic tix(input int lo, input int hi, input int v);
        for (int i = lo; i <= hi; i++) st[i] = TW'(v);
    endtask

    // Drives start for one cycle (relative cycle 0) and queues the prepared schedule
    task automatic launch(input int a, input int t, input bit acc);
        @(negedge clk);
        a_rows = AW'(a);
        tiles  = TW'(t);
        accum  = acc;
        start  = 1'b1;
        base   = cyc;
        for (int i = 0; i < 64; i++) begin
            if (sv[i] != '0) q.push_back('{base + i, sv[i], st[i]});
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic end_test(input string name);
        check(name, q.size(), 0);
        q.delete();
    endtask

    // First tile of a 3-row run with clear at cycle 1
    task automatic tile0_a3();
        rng(1, 1, B_CLR);
        rng(2, 5, B_W);
        rng(6, 8, B_IF);
        rng(10, 12, B_OV + 0);
        rng(11, 13, B_OV + 1);
        rng(12, 14, B_OV + 2);
        rng(13, 15, B_OV + 3);
        rng(15, 15, B_LAST);
    endtask

    initial begin
        #1;
        check("reset_ready", int'(ready), 1);
        check("reset_busy", int'(busy), 0);
        check("reset_strobes", int'(act_vec), 0);
        check("reset_tile_idx", int'(tile_idx), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single tile, a_rows=3
        sched_clear();
        tile0_a3();
        rng(16, 16, B_DONE);
        launch(3, 1, 1'b0);
        check("t1_busy", int'(busy), 1);
        check("t1_ready_low", int'(ready), 0);
        repeat (16) @(negedge clk);
        check("t1_ready_back", int'(ready), 1);
        end_test("t1_all_seen");

        // Two tiles, clear per tile; cfg inputs scrambled mid-run
        sched_clear();
        tile0_a3();
        rng(16, 16, B_CLR);
        rng(17, 20, B_W);
        rng(21, 23, B_IF);
        rng(25, 27, B_OV + 0);
        rng(26, 28, B_OV + 1);
        rng(27, 29, B_OV + 2);
        rng(28, 30, B_OV + 3);
        rng(30, 30, B_LAST);
        rng(31, 31, B_DONE);
        tix(16, 31, 1);
        launch(3, 2, 1'b0);
        a_rows = AW'(7);
        tiles  = TW'(5);
        accum  = 1'b1;
        repeat (17) @(negedge clk);
        check("t2_tile_idx_mid", int'(tile_idx), 1);
        repeat (16) @(negedge clk);
        end_test("t2_all_seen");

        // Two tiles, accumulate: single clear
        sched_clear();
        tile0_a3();
        rng(16, 19, B_W);
        rng(20, 22, B_IF);
        rng(24, 26, B_OV + 0);
        rng(25, 27, B_OV + 1);
        rng(26, 28, B_OV + 2);
        rng(27, 29, B_OV + 3);
        rng(29, 29, B_LAST);
        rng(30, 30, B_DONE);
        tix(16, 30, 1);
        launch(3, 2, 1'b1);
        repeat (31) @(negedge clk);
        end_test("t3_all_seen");

        // Hold between tiles: high during cycles 10..19, HOLD for 16..20
        sched_clear();
        tile0_a3();
        rng(21, 21, B_CLR);
        rng(22, 25, B_W);
        rng(26, 28, B_IF);
        rng(30, 32, B_OV + 0);
        rng(31, 33, B_OV + 1);
        rng(32, 34, B_OV + 2);
        rng(33, 35, B_OV + 3);
        rng(35, 35, B_LAST);
        rng(36, 36, B_DONE);
        tix(16, 36, 1);
        launch(3, 2, 1'b0);
        repeat (9) @(negedge clk);
        hold = 1'b1;
        repeat (8) @(negedge clk);
        check("t4_hold_busy", int'(busy), 1);
        check("t4_hold_tile_idx", int'(tile_idx), 0);
        repeat (2) @(negedge clk);
        hold = 1'b0;
        repeat (17) @(negedge clk);
        check("t4_ready_back", int'(ready), 1);
        end_test("t4_all_seen");

        // Zero tiles: immediate done
        sched_clear();
        rng(1, 1, B_DONE);
        launch(5, 0, 1'b0);
        repeat (4) @(negedge clk);
        end_test("t5_all_seen");

        // Zero activation rows clamp to one
        sched_clear();
        rng(1, 1, B_CLR);
        rng(2, 5, B_W);
        rng(6, 6, B_IF);
        rng(10, 10, B_OV + 0);
        rng(11, 11, B_OV + 1);
        rng(12, 12, B_OV + 2);
        rng(13, 13, B_OV + 3);
        rng(13, 13, B_LAST);
        rng(14, 14, B_DONE);
        launch(0, 1, 1'b0);
        repeat (16) @(negedge clk);
        end_test("t6_all_seen");

        // Reset mid-stream after a start issued while busy
        sched_clear();
        rng(1, 1, B_CLR);
        rng(2, 5, B_W);
        rng(6, 6, B_IF);
        launch(3, 1, 1'b0);
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("t7_abort_strobes", int'(act_vec), 0);
        check("t7_abort_ready", int'(ready), 1);
        check("t7_abort_busy", int'(busy), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("t7_idle_after", int'(ready), 1);
        end_test("t7_all_seen");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tile_sequencer.md
Name: tile_sequencer

Overview:
- Parametrised control core for the systolic-array datapath; generalises fixed single-pass weight/activation sequencing to multi-tile runs.
- Sequences clear, weight load, activation streaming and pipeline drain for a run-time number of tiles and activation rows per tile.
- Provides an optional accumulate-across-tiles mode and a start/done handshake.
- Generates per-column skewed output-valid strobes aligned to the array's partial-sum outputs.
- Sits between the host controller and the weight_buffer / input_buffer / sys instances.

Parameters:
- ROWS, 4, systolic array rows (weight load length, row skew).
- COLS, 4, systolic array columns (output skew).
- MAX_A_ROWS, 256, maximum activation rows per tile.
- MAX_TILES, 16, maximum tiles per run.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  run request; sampled only when ready=1.
- cfg_a_rows  in  $clog2(MAX_A_ROWS+1)  activation rows per tile; latched at start.
- cfg_tiles  in  $clog2(MAX_TILES+1)  tiles in run; latched at start.
- cfg_accum  in  1  1 = clear partial sums only before the first tile; latched at start.
- tile_hold  in  1  pauses between tiles.
- ready  out  1  idle, accepts start.
- busy  out  1  run in progress.
- sys_clr  out  1  partial-sum clear pulse.
- w_buffer_read  out  1  weight buffer read strobe.
- if_buffer_read  out  1  input buffer read strobe.
- of_valid  out  COLS  per-column output-valid strobe.
- of_last  out  1  final output of the current tile (column COLS-1).
- tile_idx  out  $clog2(MAX_TILES+1)  current tile, 0-based.
- done  out  1  one-cycle run-complete pulse.

Behaviour:
- Reset (rst=0, async):
  - State = IDLE; all counters and skew registers = 0.
  - All outputs 0 except ready=1.
  - Reset mid-run aborts immediately; no done pulse.
- States: IDLE, CLR, WLOAD, STREAM, DRAIN, HOLD, DONE.
  - busy=1 in every state except IDLE.
  - ready=1 only in IDLE.
- IDLE:
  - start=1 latches the cfg_* inputs and clears tile_idx.
  - cfg_tiles=0 -> DONE.
  - Otherwise -> CLR.
  - start while busy is ignored.
- CLR: one cycle, sys_clr=1 -> WLOAD.
- WLOAD: exactly ROWS cycles with w_buffer_read=1 -> STREAM.
- STREAM:
  - Exactly A cycles with if_buffer_read=1, where A = max(cfg_a_rows, 1); a zero value is clamped to 1.
  - -> DRAIN.
- DRAIN: exactly ROWS+COLS-1 cycles, all strobes low. On its last cycle:
  - If tile_idx = tiles-1 -> DONE.
  - Else if tile_hold=1 -> HOLD.
  - Else tile_idx+1, then CLR (cfg_accum=0) or WLOAD (cfg_accum=1).
- HOLD: stays while tile_hold=1; on release, same next-tile rule as DRAIN.
- DONE: one cycle, done=1 -> IDLE.
- tile_hold is ignored in all states other than the end of DRAIN and HOLD.
- Output skew:
  - With STREAM beginning at cycle t0, of_valid[c] is high for cycles t0+ROWS+c .. t0+ROWS+c+A-1.
  - of_last is high together with the final of_valid[COLS-1] of each tile, i.e. the last DRAIN cycle.
  - Tiles never overlap: no WLOAD during DRAIN in this generation.
- Latched configuration is immune to changes on the cfg_* inputs during a run.
- Counters:
  - Phase counter width $clog2(max(MAX_A_ROWS, ROWS+COLS)+1).
  - Compares are against the latched values minus 1.
  - No wrap occurs inside a phase.

Decomposition:
- Config package:
  - ROWS/COLS defaults tied to sys_rows/sys_cols.
  - Typedef tseq_state_e for the state enum.
  - Width localparams for the a_rows, tile and phase counters.
- Sub-module valid_skew (params ROWS, COLS):
  - Shift register fed by if_buffer_read.
  - Produces of_valid[COLS-1:0] and of_last.
  - Cleared by rst.

Test Plan:
- ROWS=COLS=4, a_rows=3, tiles=1, accum=0; start sampled at edge 0 ->
  - sys_clr at cycle 1; w_buffer_read at 2-5; if_buffer_read at 6-8.
  - of_valid[0] at 10-12; of_valid[3] at 13-15; of_last at 15.
  - done at 16; ready at 17.
- Same config, tiles=2, accum=0 ->
  - Second tile: sys_clr at 16, WLOAD 17-20, STREAM 21-23, of_last at 30.
  - done at 31; tile_idx=1 during 16-31.
- tiles=2, accum=1 -> single sys_clr at 1; second WLOAD at 16-19; done at 30.
- tile_hold=1 from cycle 10 to 20, tiles=2 -> HOLD for cycles 16-20; second-tile sys_clr at 21; no strobes during HOLD.
- cfg_tiles=0 -> done at cycle 1, no read strobes; cfg_a_rows=0 -> behaves as a_rows=1 (one if_buffer_read cycle).
- rst pulled low during STREAM, start re-issued while busy ->
  - All strobes and of_valid go 0 asynchronously; ready=1; no done.
  - A start pulse asserted mid-run has no effect.
